// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin address arbiter.
// Holds the FSM state encoding and the width helper.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Bits needed to hold 0..v-1, never below 1.
  function automatic int clog2_min1(input int v);
    int w;
    w = 0;
    while ((1 << w) < v) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search.
// Rotates by ptr, finds the first set bit, rotates back mod NUM_REQ.
module rr_pick
  import arb_pkg::*;
#(
  parameter int NUM_REQ = 5,
  parameter int ADDR_W  = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ADDR_W-1:0]  ptr,
  output logic [ADDR_W-1:0]  idx,
  output logic               any
);

  localparam logic [ADDR_W:0] NW = (ADDR_W+1)'(NUM_REQ);

  function automatic logic [ADDR_W-1:0] wrap_add(
    input logic [ADDR_W-1:0] a,
    input logic [ADDR_W-1:0] b
  );
    logic [ADDR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= NW) s = s - NW;
    return s[ADDR_W-1:0];
  endfunction

  logic [NUM_REQ-1:0] rot;
  logic [ADDR_W-1:0]  first;

  // Rotate so that bit 0 of rot is the requester at ptr.
  always_comb begin
    rot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rot[k] = req[wrap_add(ptr, ADDR_W'(k))];
    end
  end

  // Lowest set bit of the rotated vector.
  always_comb begin
    first = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) first = ADDR_W'(k);
    end
  end

  assign any = |req;
  assign idx = wrap_add(ptr, first);

endmodule

// File: rtl/rr_addr_arbiter.sv
// Round-robin arbiter producing a registered binary grant address.
// Grants are held until release or until the hold timer expires.
module rr_addr_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = 5,
  parameter int MAX_HOLD = 8,
  localparam int ADDR_W  = $clog2(NUM_REQ)
) (
  input  logic               in_clk,
  input  logic               in_rst_n,
  input  logic [NUM_REQ-1:0] in_req,
  input  logic               in_release,
  output logic [ADDR_W-1:0]  out_address,
  output logic               out_valid,
  output logic               out_timeout
);

  localparam int CNT_W = clog2_min1(MAX_HOLD + 1);
  localparam bit TMO_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST =
    TMO_EN ? CNT_W'(MAX_HOLD - 1) : '0;
  localparam logic [ADDR_W-1:0] LAST_REQ = ADDR_W'(NUM_REQ - 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [ADDR_W-1:0] addr_n;
  logic              valid_n;
  logic              tmo_n;
  logic [ADDR_W-1:0] pick_idx;
  logic              pick_any;
  logic [ADDR_W-1:0] next_ptr;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W)
  ) u_pick (
    .req (in_req),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign next_ptr = (out_address == LAST_REQ) ? '0 : out_address + 1'b1;

  // Next-state, pointer, counter and output register inputs.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    addr_n  = out_address;
    valid_n = out_valid;
    tmo_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          addr_n  = pick_idx;
          valid_n = 1'b1;
          cnt_n   = '0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (in_release) begin
          valid_n = 1'b0;
          ptr_n   = next_ptr;
          state_n = IDLE;
        end else if (TMO_EN && cnt == HOLD_LAST) begin
          valid_n = 1'b0;
          ptr_n   = next_ptr;
          tmo_n   = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      out_address <= '0;
      out_valid   <= 1'b0;
      out_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      cnt         <= cnt_n;
      out_address <= addr_n;
      out_valid   <= valid_n;
      out_timeout <= tmo_n;
    end
  end

endmodule

// File: tb/tb_rr_addr_arbiter.sv
// Self-checking bench for rr_addr_arbiter with a behavioural model
// and a small one-hot decoder attached to out_address.
module tb_rr_addr_arbiter;

  localparam int N  = 5;
  localparam int MH = 8;

  logic       in_clk;
  logic       in_rst_n;
  logic [4:0] in_req;
  logic       in_release;
  logic [2:0] out_address;
  logic       out_valid;
  logic       out_timeout;

  logic [4:0] sel;
  logic       derr;

  int n_checks;
  int n_fail;

  bit m_valid;
  bit m_to;
  int m_addr;
  int m_ptr;
  int m_age;

  rr_addr_arbiter #(
    .NUM_REQ  (N),
    .MAX_HOLD (MH)
  ) dut (
    .in_clk      (in_clk),
    .in_rst_n    (in_rst_n),
    .in_req      (in_req),
    .in_release  (in_release),
    .out_address (out_address),
    .out_valid   (out_valid),
    .out_timeout (out_timeout)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  always_comb begin
    sel  = '0;
    derr = 1'b0;
    if (out_address < 3'd5) sel[out_address] = 1'b1;
    else derr = 1'b1;
  end

  task automatic tick(input logic [4:0] req, input logic rel,
                      input logic rst_n);
    in_req     = req;
    in_release = rel;
    in_rst_n   = rst_n;
    @(posedge in_clk);
    #1;
    if (!rst_n) begin
      m_valid = 0; m_to = 0; m_addr = 0; m_ptr = 0; m_age = 0;
    end else begin
      m_to = 0;
      if (!m_valid) begin
        if (req != 0) begin
          for (int k = N - 1; k >= 0; k--)
            if (req[(m_ptr + k) % N]) m_addr = (m_ptr + k) % N;
          m_valid = 1;
          m_age   = 1;
        end
      end else if (rel) begin
        m_valid = 0;
        m_ptr   = (m_addr + 1) % N;
      end else if (MH != 0 && m_age == MH) begin
        m_valid = 0;
        m_ptr   = (m_addr + 1) % N;
        m_to    = 1;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) tick(5'($urandom), 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || out_address !== 3'd0 ||
        out_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: v=%b a=%0d t=%b want 0 0 0",
               out_valid, out_address, out_timeout);
    end
    n_checks++;
    if (sel !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_sel: got %b want 00001", sel);
    end
  endtask

  task automatic test_single();
    tick(5'b00100, 1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_address !== 3'd2 ||
        sel !== 5'b00100) begin
      n_fail++;
      $display("FAIL single_grant: v=%b a=%0d sel=%b want 1 2 00100",
               out_valid, out_address, sel);
    end
    tick(5'b00000, 1'b1, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0 || dut.ptr !== 3'd3) begin
      n_fail++;
      $display("FAIL single_release: v=%b ptr=%0d want 0 3",
               out_valid, dut.ptr);
    end
  endtask

  task automatic test_round_robin();
    int exp_seq [7] = '{0, 1, 2, 3, 4, 0, 1};
    bit bad_addr;
    bad_addr = 0;
    tick(5'b00000, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick(5'b11111, 1'b0, 1'b1);
      if (derr || out_address > 3'd4) bad_addr = 1;
      n_checks++;
      if (out_valid !== 1'b1 || out_address !== 3'(exp_seq[i])) begin
        n_fail++;
        $display("FAIL rr_grant%0d: v=%b a=%0d want 1 %0d",
                 i, out_valid, out_address, exp_seq[i]);
      end
      tick(5'b11111, 1'b1, 1'b1);
      if (derr || out_address > 3'd4) bad_addr = 1;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_gap%0d: v=%b want 0", i, out_valid);
      end
    end
    n_checks++;
    if (bad_addr) begin
      n_fail++;
      $display("FAIL rr_addr_range: got bad=1 want 0");
    end
  endtask

  task automatic test_pointer_skip();
    tick(5'b01000, 1'b0, 1'b1);
    tick(5'b00000, 1'b1, 1'b1);
    n_checks++;
    if (dut.ptr !== 3'd4) begin
      n_fail++;
      $display("FAIL skip_ptr: got %0d want 4", dut.ptr);
    end
    tick(5'b01001, 1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_address !== 3'd0) begin
      n_fail++;
      $display("FAIL skip_first: v=%b a=%0d want 1 0",
               out_valid, out_address);
    end
    tick(5'b01001, 1'b1, 1'b1);
    tick(5'b01001, 1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_address !== 3'd3) begin
      n_fail++;
      $display("FAIL skip_second: v=%b a=%0d want 1 3",
               out_valid, out_address);
    end
    tick(5'b00000, 1'b1, 1'b1);
  endtask

  task automatic test_timeout();
    int hi;
    int pulses;
    bit done;
    hi = 0; pulses = 0; done = 0;
    tick(5'b00010, 1'b0, 1'b1);
    for (int i = 0; i < 20 && !done; i++) begin
      if (out_valid) hi++;
      if (out_timeout) pulses++;
      if (!out_valid) done = 1;
      else tick(5'b00010, 1'b0, 1'b1);
    end
    n_checks++;
    if (hi != MH || !done) begin
      n_fail++;
      $display("FAIL timeout_len: got %0d want %0d", hi, MH);
    end
    n_checks++;
    if (out_timeout !== 1'b1 || pulses != 1) begin
      n_fail++;
      $display("FAIL timeout_pulse: t=%b n=%0d want 1 1",
               out_timeout, pulses);
    end
    tick(5'b00010, 1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_address !== 3'd1 ||
        out_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_regrant: v=%b a=%0d t=%b want 1 1 0",
               out_valid, out_address, out_timeout);
    end
    for (int i = 0; i < MH - 2; i++) tick(5'b00010, 1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_hold8: v=%b want 1", out_valid);
    end
    tick(5'b00010, 1'b1, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0 || out_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL release_wins: v=%b t=%b want 0 0",
               out_valid, out_timeout);
    end
    tick(5'b00000, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    tick(5'b01000, 1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_address !== 3'd3) begin
      n_fail++;
      $display("FAIL mid_grant: v=%b a=%0d want 1 3",
               out_valid, out_address);
    end
    tick(5'b01000, 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || out_address !== 3'd0 ||
        out_timeout !== 1'b0 || dut.ptr !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_reset: v=%b a=%0d t=%b p=%0d want 0 0 0 0",
               out_valid, out_address, out_timeout, dut.ptr);
    end
    tick(5'b11111, 1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_address !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_regrant: v=%b a=%0d want 1 0",
               out_valid, out_address);
    end
  endtask

  task automatic test_random();
    logic [4:0] r;
    logic       rl;
    logic       rs;
    for (int i = 0; i < 400; i++) begin
      r  = 5'($urandom);
      if ($urandom_range(3) == 0) r = '0;
      rl = ($urandom_range(5) == 0);
      rs = ($urandom_range(60) != 0);
      tick(r, rl, rs);
      n_checks++;
      if (out_valid !== m_valid || out_address !== 3'(m_addr) ||
          out_timeout !== m_to || derr !== 1'b0) begin
        n_fail++;
        $display("FAIL random%0d: v=%b a=%0d t=%b e=%b want %b %0d %b 0",
                 i, out_valid, out_address, out_timeout, derr,
                 m_valid, m_addr, m_to);
      end
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    in_rst_n   = 1'b0;
    in_req     = '0;
    in_release = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_pointer_skip();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
